rrv64_axi_rd_burst_split: RTL and testbench
===========================================

# rrv64_axi_rd_burst_split

Parametrised AXI read-burst splitter between an uncore-side master (8-bit `arlen`) and a downstream port with a shorter maximum burst. It accepts one upstream AR, issues it downstream as a sequence of sub-bursts no longer than `MAX_SUB_BEATS`, and optionally never crosses a 4 KB page. It returns the downstream R beats upstream with a single merged `rlast`. It generalises the fixed-width L1D/uncore AR/R channel types to any width and burst limit, and sits between uncore-out AXI masters and narrower-burst interconnect ports.

## Interface
- `ADDR_W`, 40: `araddr` width.
- `ID_W`, 4: `arid`/`rid` width.
- `DATA_W`, 64: `rdata` width.
- `MAX_SUB_BEATS`, 16: maximum beats per downstream burst; power of two, 1..256.
- `clk`  in  1  single clock; all state on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `s_ar_valid`/`s_ar_ready`  in/out  1  upstream AR handshake.
- `s_araddr`, `s_arid`, `s_arlen`, `s_arsize`, `s_arburst`  in  ADDR_W/ID_W/8/3/2  upstream AR fields.
- `s_arcache`, `s_arprot`  in  4/3  forwarded unchanged.
- `m_ar_valid`/`m_ar_ready`  out/in  1  downstream AR handshake.
- `m_araddr`, `m_arid`, `m_arlen`, `m_arsize`, `m_arburst`, `m_arcache`, `m_arprot`  out  ADDR_W/ID_W/8/3/2/4/3  sub-burst fields.
- `m_r_valid`/`m_r_ready`  in/out  1  downstream R handshake.
- `m_rdata`, `m_rid`, `m_rresp`, `m_rlast`  in  DATA_W/ID_W/2/1  downstream R fields.
- `s_r_valid`/`s_r_ready`  out/in  1  upstream R handshake.
- `s_rdata`, `s_rid`, `s_rresp`, `s_rlast`  out  DATA_W/ID_W/2/1  upstream R fields.
- `busy`  out  1  a transaction is in flight (state ≠ IDLE).

## Operation
- FSM states:
  - IDLE: `s_ar_ready=1`. On the handshake, latch all AR fields into a command register, set `rem_beats = arlen+1` (9 bits), clear `issued`/`done` (9 bits each), then go to ISSUE.
  - ISSUE: present the sub-burst on `m_ar_*`.
    - `sub = min(rem_beats, MAX_SUB_BEATS, beats_to_4k)` for INCR.
    - `beats_to_4k = (4096 - addr[11:0]) >> arsize`.
    - `m_arlen = sub-1`.
    - On `m_ar` handshake: `rem_beats -= sub`, `issued++`; for INCR `addr += sub << arsize`; for FIXED the address is unchanged.
    - When `rem_beats` reaches 0, go to DRAIN.
  - DRAIN: wait until the R handshake carrying the final `rlast`, then go to IDLE.
- WRAP bursts are issued unsplit as a single sub-burst; AXI limits WRAP to 16 beats.
- `m_arid` is always the latched id. `m_arcache`/`m_arprot` are the latched values.
- R path is combinational: `s_r_valid=m_r_valid`, `m_r_ready=s_r_ready`, and `s_rdata`/`s_rresp` are passed through.
- `s_rid` is the latched id.
- Each `m_rlast` handshake increments `done`.
- `s_rlast = m_rlast && (state==DRAIN || rem_beats==0) && done==issued-1`. This holds even when the final sub-burst's last beat coincides with entry to DRAIN.
- Downstream R beats are returned in order; sub-bursts use the same id.
- Error responses are forwarded per beat; they do not abort remaining sub-bursts.
- R beats may arrive during ISSUE. `done` and `issued` may update in the same cycle.

## Timing
- Reset values: state IDLE, `s_ar_ready=1` (derived from IDLE), `m_ar_valid=0`, `busy=0`, counters 0, command register 0.
- `s_r_valid` is combinational and follows `m_r_valid`, so it can be high in reset only if downstream drives it.
- First `m_ar_valid` rises the cycle after the `s_ar` handshake.
- Sub-bursts issue back-to-back, one per cycle while `m_ar_ready=1`.
- `m_ar_*` stay stable while `m_ar_valid && !m_ar_ready`.
- R latency through the block is 0 cycles.
- `s_ar_ready` returns the cycle after the final `s_rlast` handshake, so there is one upstream transaction at a time.
- Asserting `rstn` low mid-burst returns to IDLE immediately. Downstream in-flight beats must be discarded by the system reset.

## Configuration
- `RRV64_AXI_SPLIT_4K_EN`:
  - Defined: INCR sub-bursts are additionally clipped at 4 KB boundaries.
  - Undefined: `beats_to_4k` is treated as infinite; only `MAX_SUB_BEATS` limits `sub`.

## Structure
- Shared package `rrv64_axi_split_pkg`:
  - Parametrised-width-independent burst-type constants (FIXED=2'b00, INCR=2'b01, WRAP=2'b10).
  - FSM state enum `axi_split_state_e`.
  - Function `axi_split_sub_beats(rem, addr_lo, size, max)`.
- One sub-module, `rrv64_axi_split_len_calc`: combinational `sub` computation, unit-testable alone.

## Test plan
- INCR, `araddr=0x1000`, `arsize=3`, `arlen=63`, MAX 16 → 4 sub-bursts at 0x1000/0x1080/0x1100/0x1180, each `arlen=15`. 64 upstream beats; `s_rlast` only on beat 64.
- With the macro, INCR `araddr=0x1FC0`, `arsize=3`, `arlen=15` → sub-bursts 0x1FC0 len 7 and 0x2000 len 7. Without the macro → a single burst 0x1FC0 len 15.
- FIXED `araddr=0x40`, `arlen=31` → two sub-bursts, both 0x40, len 15. `s_rlast` on beat 32.
- `arlen=0` → one sub-burst, len 0. The single beat carries `s_rlast=1`. `s_ar_ready` is 1 on the following cycle.
- Hold `m_ar_ready=0` for 5 cycles during the second sub-burst → `m_ar_*` held stable. Interleave R beats; `s_rresp=SLVERR` is passed on beat 20 and the transfer completes normally.
- Pull `rstn` low during ISSUE of a 4-sub-burst request → the next cycle shows `m_ar_valid=0`, `busy=0`, `s_ar_ready=1`.

Source files
------------

// File: rtl/rrv64_axi_split_pkg.sv
// Shared types and sub-burst sizing helper for the AXI read-burst splitter.
// Optional macro RRV64_AXI_SPLIT_4K_EN enables clipping of INCR sub-bursts at 4 KB pages.
package rrv64_axi_split_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

`ifdef RRV64_AXI_SPLIT_4K_EN
    localparam bit AXI_SPLIT_4K_EN = 1'b1;
`else
    localparam bit AXI_SPLIT_4K_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } axi_split_state_e;

    // Beats of the next INCR sub-burst: min(remaining, burst limit, beats left in the 4 KB page).
    function automatic logic [8:0] axi_split_sub_beats(
        input logic [8:0]  rem,
        input logic [11:0] addr_lo,
        input logic [2:0]  size,
        input logic [8:0]  max
    );
        logic [12:0] to_4k;
        logic [8:0]  sub;
        sub   = (rem < max) ? rem : max;
        to_4k = (13'd4096 - {1'b0, addr_lo}) >> size;
        // An unaligned last beat in the page still has to make progress.
        if (to_4k == 13'd0) begin
            to_4k = 13'd1;
        end
        if (AXI_SPLIT_4K_EN && (to_4k < {4'b0, sub})) begin
            sub = to_4k[8:0];
        end
        return sub;
    endfunction

endpackage

// File: rtl/rrv64_axi_rd_burst_split_if.sv
// AXI read channel bundle (AR + R) shared by the upstream and downstream sides of the splitter.
interface rrv64_axi_rd_burst_split_if #(
    parameter int unsigned ADDR_W = 40,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned DATA_W = 64
);
    logic              ar_valid;
    logic              ar_ready;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [3:0]        arcache;
    logic [2:0]        arprot;

    logic              r_valid;
    logic              r_ready;
    logic [DATA_W-1:0] rdata;
    logic [ID_W-1:0]   rid;
    logic [1:0]        rresp;
    logic              rlast;

    modport master (
        output ar_valid, araddr, arid, arlen, arsize, arburst, arcache, arprot,
        input  ar_ready,
        input  r_valid, rdata, rid, rresp, rlast,
        output r_ready
    );

    modport slave (
        input  ar_valid, araddr, arid, arlen, arsize, arburst, arcache, arprot,
        output ar_ready,
        output r_valid, rdata, rid, rresp, rlast,
        input  r_ready
    );

endinterface

// File: rtl/rrv64_axi_split_len_calc.sv
// Combinational beat count of the next downstream sub-burst.
// 4 KB clipping of INCR bursts follows RRV64_AXI_SPLIT_4K_EN through the package helper.
module rrv64_axi_split_len_calc
    import rrv64_axi_split_pkg::*;
#(
    parameter int unsigned MAX_SUB_BEATS = 16
) (
    input  logic [8:0]  rem,
    input  logic [11:0] addr_lo,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [8:0]  sub
);
    localparam logic [8:0] MaxBeats = 9'(MAX_SUB_BEATS);

    logic [8:0] rem_capped;

    assign rem_capped = (rem < MaxBeats) ? rem : MaxBeats;

    always_comb begin
        sub = rem_capped;
        case (burst)
            AXI_BURST_INCR: sub = axi_split_sub_beats(rem, addr_lo, size, MaxBeats);
            // WRAP is at most 16 beats and must not be broken up.
            AXI_BURST_WRAP: sub = rem;
            default:        sub = rem_capped;
        endcase
    end

endmodule

// File: rtl/rrv64_axi_rd_burst_split.sv
// AXI read-burst splitter: one upstream AR becomes a run of shorter downstream sub-bursts.
// Define RRV64_AXI_SPLIT_4K_EN to also split INCR bursts at 4 KB page boundaries.
module rrv64_axi_rd_burst_split
    import rrv64_axi_split_pkg::*;
#(
    parameter int unsigned ADDR_W        = 40,
    parameter int unsigned ID_W          = 4,
    parameter int unsigned DATA_W        = 64,
    parameter int unsigned MAX_SUB_BEATS = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    rrv64_axi_rd_burst_split_if.slave     s,
    rrv64_axi_rd_burst_split_if.master    m,
    output logic                          busy
);
    axi_split_state_e  state_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [ID_W-1:0]   cmd_id_q;
    logic [2:0]        cmd_size_q;
    logic [1:0]        cmd_burst_q;
    logic [3:0]        cmd_cache_q;
    logic [2:0]        cmd_prot_q;
    logic [8:0]        rem_q;
    logic [8:0]        issued_q;
    logic [8:0]        done_q;
    logic              ar_valid_q;
    logic              ar_ready_q;
    logic              busy_q;

    logic [8:0]        sub;
    logic [8:0]        rem_next;
    logic [ADDR_W-1:0] addr_step;
    logic              ar_hs;
    logic              r_hs;
    logic              rlast_merged;
    logic [DATA_W-1:0] rdata_pass;

    rrv64_axi_split_len_calc #(
        .MAX_SUB_BEATS (MAX_SUB_BEATS)
    ) u_len_calc (
        .rem     (rem_q),
        .addr_lo (cmd_addr_q[11:0]),
        .size    (cmd_size_q),
        .burst   (cmd_burst_q),
        .sub     (sub)
    );

    assign rem_next  = rem_q - sub;
    assign addr_step = {{(ADDR_W-9){1'b0}}, sub} << cmd_size_q;
    assign ar_hs     = ar_valid_q && m.ar_ready;
    assign r_hs      = m.r_valid && s.r_ready;

    // Only the last beat of the last issued sub-burst closes the upstream burst.
    assign rlast_merged = m.rlast && ((state_q == StDrain) || (rem_q == 9'd0)) &&
                          (done_q == issued_q - 9'd1);

    assign s.ar_ready = ar_ready_q;
    assign busy       = busy_q;

    assign m.ar_valid = ar_valid_q;
    assign m.araddr   = cmd_addr_q;
    assign m.arid     = cmd_id_q;
    assign m.arlen    = 8'(sub - 9'd1);
    assign m.arsize   = cmd_size_q;
    assign m.arburst  = cmd_burst_q;
    assign m.arcache  = cmd_cache_q;
    assign m.arprot   = cmd_prot_q;

    assign rdata_pass = m.rdata;
    assign s.r_valid  = m.r_valid;
    assign m.r_ready  = s.r_ready;
    assign s.rdata    = rdata_pass;
    assign s.rresp    = m.rresp;
    assign s.rid      = cmd_id_q;
    assign s.rlast    = rlast_merged;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            cmd_addr_q  <= '0;
            cmd_id_q    <= '0;
            cmd_size_q  <= '0;
            cmd_burst_q <= '0;
            cmd_cache_q <= '0;
            cmd_prot_q  <= '0;
            rem_q       <= '0;
            issued_q    <= '0;
            done_q      <= '0;
            ar_valid_q  <= 1'b0;
            ar_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            if (r_hs && m.rlast) begin
                done_q <= done_q + 9'd1;
            end
            unique case (state_q)
                StIdle: begin
                    if (s.ar_valid) begin
                        cmd_addr_q  <= s.araddr;
                        cmd_id_q    <= s.arid;
                        cmd_size_q  <= s.arsize;
                        cmd_burst_q <= s.arburst;
                        cmd_cache_q <= s.arcache;
                        cmd_prot_q  <= s.arprot;
                        rem_q       <= {1'b0, s.arlen} + 9'd1;
                        issued_q    <= '0;
                        done_q      <= '0;
                        ar_valid_q  <= 1'b1;
                        ar_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    if (ar_hs) begin
                        rem_q    <= rem_next;
                        issued_q <= issued_q + 9'd1;
                        if (cmd_burst_q == AXI_BURST_INCR) begin
                            cmd_addr_q <= cmd_addr_q + addr_step;
                        end
                        if (rem_next == 9'd0) begin
                            ar_valid_q <= 1'b0;
                            state_q    <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (r_hs && rlast_merged) begin
                        ar_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rrv64_axi_rd_burst_split.sv
// Directed self-checking bench for rrv64_axi_rd_burst_split (upstream master + downstream slave).
module tb_rrv64_axi_rd_burst_split;
    import rrv64_axi_split_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    logic busy;

    always #5 clk = ~clk;

    rrv64_axi_rd_burst_split_if #(.ADDR_W(40), .ID_W(4), .DATA_W(64)) s_bus ();
    rrv64_axi_rd_burst_split_if #(.ADDR_W(40), .ID_W(4), .DATA_W(64)) m_bus ();

    rrv64_axi_rd_burst_split #(
        .ADDR_W        (40),
        .ID_W          (4),
        .DATA_W        (64),
        .MAX_SUB_BEATS (16)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .s    (s_bus),
        .m    (m_bus),
        .busy (busy)
    );

    int checks   = 0;
    int failures = 0;

    logic [39:0] ar_addr_q[$];
    logic [7:0]  ar_len_q[$];
    logic [3:0]  cur_id;

    always @(posedge clk) begin
        if (rstn && m_bus.ar_valid && m_bus.ar_ready) begin
            ar_addr_q.push_back(m_bus.araddr);
            ar_len_q.push_back(m_bus.arlen);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_ar(input logic [39:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        ar_addr_q.delete();
        ar_len_q.delete();
        cur_id          = id;
        s_bus.ar_valid  = 1'b1;
        s_bus.araddr    = addr;
        s_bus.arid      = id;
        s_bus.arlen     = len;
        s_bus.arsize    = size;
        s_bus.arburst   = burst;
        s_bus.arcache   = 4'h3;
        s_bus.arprot    = 3'h2;
        #1;
        check("s_ar_ready_idle", s_bus.ar_ready, 1);
        @(negedge clk);
        s_bus.ar_valid  = 1'b0;
        check("m_ar_valid_next", m_bus.ar_valid, 1);
        check("m_arid", m_bus.arid, id);
        check("m_arcache", m_bus.arcache, 4'h3);
        check("busy_issue", busy, 1);
    endtask

    task automatic wait_ar(input int n);
        int cnt = 0;
        while (ar_addr_q.size() < n && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("ar_count", ar_addr_q.size(), n);
    endtask

    task automatic r_beat(input int beat, input bit sub_last, input int total, input int err_beat);
        logic [1:0] resp;
        resp           = (beat == err_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        m_bus.r_valid  = 1'b1;
        m_bus.rlast    = sub_last;
        m_bus.rdata    = 64'hD000 + 64'(beat);
        m_bus.rresp    = resp;
        m_bus.rid      = cur_id;
        s_bus.r_ready  = 1'b1;
        #1;
        check("s_r_valid", s_bus.r_valid, 1);
        check("s_rlast", s_bus.rlast, beat == total - 1);
        check("s_rresp", s_bus.rresp, resp);
        check("s_rdata", s_bus.rdata, 64'hD000 + 64'(beat));
        check("s_rid", s_bus.rid, cur_id);
        @(negedge clk);
        m_bus.r_valid  = 1'b0;
        m_bus.rlast    = 1'b0;
    endtask

    task automatic serve_queue(input int total, input int err_beat);
        int b = 0;
        foreach (ar_len_q[k]) begin
            for (int j = 0; j <= int'(ar_len_q[k]); j++) begin
                r_beat(b, j == int'(ar_len_q[k]), total, err_beat);
                b++;
            end
        end
        check("beat_total", b, total);
    endtask

    task automatic check_idle_again();
        check("s_ar_ready_back", s_bus.ar_ready, 1);
        check("busy_done", busy, 0);
    endtask

    initial begin
        rstn           = 1'b0;
        cur_id         = '0;
        s_bus.ar_valid = 1'b0;
        s_bus.araddr   = '0;
        s_bus.arid     = '0;
        s_bus.arlen    = '0;
        s_bus.arsize   = '0;
        s_bus.arburst  = '0;
        s_bus.arcache  = '0;
        s_bus.arprot   = '0;
        s_bus.r_ready  = 1'b0;
        m_bus.ar_ready = 1'b1;
        m_bus.r_valid  = 1'b0;
        m_bus.rdata    = '0;
        m_bus.rid      = '0;
        m_bus.rresp    = '0;
        m_bus.rlast    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s_ar_ready", s_bus.ar_ready, 1);
        check("rst_m_ar_valid", m_bus.ar_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_s_rid", s_bus.rid, 0);
        rstn = 1'b1;
        @(negedge clk);

        // INCR 64 beats -> four 16-beat sub-bursts
        send_ar(40'h1000, 4'h5, 8'd63, 3'd3, AXI_BURST_INCR);
        check("t1_first_addr", m_bus.araddr, 40'h1000);
        wait_ar(4);
        for (int k = 0; k < 4; k++) begin
            check("t1_sub_addr", ar_addr_q[k], 40'h1000 + 40'(k * 'h80));
            check("t1_sub_len", ar_len_q[k], 8'd15);
        end
        serve_queue(64, -1);
        check_idle_again();

        // INCR crossing a 4 KB page
        send_ar(40'h1FC0, 4'h6, 8'd15, 3'd3, AXI_BURST_INCR);
`ifdef RRV64_AXI_SPLIT_4K_EN
        wait_ar(2);
        check("t2_sub0_addr", ar_addr_q[0], 40'h1FC0);
        check("t2_sub0_len", ar_len_q[0], 8'd7);
        check("t2_sub1_addr", ar_addr_q[1], 40'h2000);
        check("t2_sub1_len", ar_len_q[1], 8'd7);
`else
        wait_ar(1);
        check("t2_sub0_addr", ar_addr_q[0], 40'h1FC0);
        check("t2_sub0_len", ar_len_q[0], 8'd15);
`endif
        serve_queue(16, -1);
        check_idle_again();

        // FIXED 32 beats -> two sub-bursts at the same address
        send_ar(40'h40, 4'h7, 8'd31, 3'd3, AXI_BURST_FIXED);
        wait_ar(2);
        for (int k = 0; k < 2; k++) begin
            check("t3_sub_addr", ar_addr_q[k], 40'h40);
            check("t3_sub_len", ar_len_q[k], 8'd15);
        end
        serve_queue(32, -1);
        check_idle_again();

        // Single-beat request
        send_ar(40'h80, 4'h9, 8'd0, 3'd3, AXI_BURST_INCR);
        wait_ar(1);
        check("t4_len", ar_len_q[0], 8'd0);
        serve_queue(1, -1);
        check_idle_again();

        // AR backpressure during the second sub-burst, R beats interleaved, SLVERR on beat 20
        m_bus.ar_ready = 1'b0;
        send_ar(40'h3000, 4'hA, 8'd63, 3'd3, AXI_BURST_INCR);
        m_bus.ar_ready = 1'b1;
        @(negedge clk);
        m_bus.ar_ready = 1'b0;
        check("t5_first_count", ar_addr_q.size(), 1);
        check("t5_first_addr", ar_addr_q[0], 40'h3000);
        for (int i = 0; i < 16; i++) begin
            if (i < 5) begin
                check("t5_hold_valid", m_bus.ar_valid, 1);
                check("t5_hold_addr", m_bus.araddr, 40'h3080);
                check("t5_hold_len", m_bus.arlen, 8'd15);
            end
            r_beat(i, i == 15, 64, 19);
        end
        m_bus.ar_ready = 1'b1;
        wait_ar(4);
        for (int k = 1; k < 4; k++) begin
            check("t5_sub_addr", ar_addr_q[k], 40'h3000 + 40'(k * 'h80));
            check("t5_sub_len", ar_len_q[k], 8'd15);
        end
        for (int b = 16; b < 64; b++) begin
            r_beat(b, (b % 16) == 15, 64, 19);
        end
        check_idle_again();

        // Asynchronous reset while sub-bursts are still being issued
        m_bus.ar_ready = 1'b0;
        send_ar(40'h5000, 4'h3, 8'd63, 3'd3, AXI_BURST_INCR);
        @(negedge clk);
        check("t6_busy_before", busy, 1);
        rstn = 1'b0;
        #1;
        check("t6_rst_m_ar_valid", m_bus.ar_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_s_ar_ready", s_bus.ar_ready, 1);
        @(negedge clk);
        rstn = 1'b1;
        m_bus.ar_ready = 1'b1;
        @(negedge clk);
        check("t6_idle_after", s_bus.ar_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
